fall_scheduler: RTL and testbench

- Sequences the falling-character display RAM (COLS×ROWS cells, one ASCII byte per cell, 0 = empty) through a single read/write port.
- On each game tick, sweeps the RAM from the last cell to cell 0 and moves every non-empty cell down one row (addr+COLS). Characters already in the bottom row are dropped and counted as misses.
- Shares the same port with two requesters: spawn, which writes a character into row 0, and clear, which erases a cell on a key hit.
- Sits between the game logic and display_ram; the VGA reader uses a separate read port.

---
 rtl/fall_pkg.sv | 12 +
 rtl/fall_cursor.sv | 33 +++
 rtl/fall_scheduler.sv | 125 ++++++++++++
 tb/tb_fall_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fall_pkg.sv
// fall_pkg: shared geometry, widths and sweep states for the fall scheduler
package fall_pkg;
    localparam int COLS   = 70;
    localparam int ROWS   = 29;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    typedef enum logic [2:0] {IDLE, RD, CHK, MV, CL, SRV} state_t;
endpackage

// File: rtl/fall_cursor.sv
// fall_cursor: walks cell addresses from the last cell down to 0 while tracking row and column
module fall_cursor
    import fall_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    output logic [ADDR_W-1:0] p,
    output logic              is_last_row,
    output logic              is_zero
);
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    // row/col follow p by wrapping the column instead of dividing the address
    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            row <= '0;
            col <= '0;
        end else if (load) begin
            p   <= ADDR_W'(CELLS - 1);
            row <= ROW_W'(ROWS - 1);
            col <= COL_W'(COLS - 1);
        end else if (dec) begin
            p   <= p - 1'b1;
            col <= (col == '0) ? COL_W'(COLS - 1) : col - 1'b1;
            row <= (col == '0) ? row - 1'b1 : row;
        end
    end
    assign is_last_row = row == ROW_W'(ROWS - 1);
    assign is_zero     = p == '0;
endmodule

// File: rtl/fall_scheduler.sv
// fall_scheduler: shares one RAM port between the bottom-up fall sweep, clear and spawn writes
module fall_scheduler
    import fall_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              spawn_req,
    input  logic [COL_W-1:0]  spawn_col,
    input  logic [DATA_W-1:0] spawn_char,
    output logic              spawn_ack,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] clr_addr,
    output logic              clr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic              miss_pulse,
    output logic              overrun
);
    state_t            state;
    logic              tick_pending;
    logic [ADDR_W-1:0] p;
    logic              is_last_row;
    logic              is_zero;
    logic              cell_done;
    logic              advance;
    logic              start;
    logic              take_clr;

    fall_cursor u_cursor (
        .clk         (clk),
        .rst         (rst),
        .load        (start),
        .dec         (advance),
        .p           (p),
        .is_last_row (is_last_row),
        .is_zero     (is_zero)
    );

    // a cell ends after an empty read or after its source is cleared; clears win every boundary
    always_comb begin
        cell_done = (state == CHK && ram_rdata == '0) || state == CL;
        advance   = cell_done && !is_zero;
        start     = state == IDLE && !clr_req && !spawn_req && (tick || tick_pending);
        take_clr  = clr_req && (state == IDLE || advance);
    end

    // sweep/arbitration FSM; every bus signal is registered so it is valid for the whole state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            spawn_ack    <= 1'b0;
            clr_ack      <= 1'b0;
            miss_cnt     <= '0;
            miss_pulse   <= 1'b0;
            overrun      <= 1'b0;
            tick_pending <= 1'b0;
        end else begin
            clr_ack      <= 1'b0;
            spawn_ack    <= 1'b0;
            miss_pulse   <= 1'b0;
            overrun      <= overrun | (tick & busy);
            tick_pending <= start ? 1'b0 : tick_pending | tick;
            case (state)
                IDLE: begin
                    if (spawn_req && !clr_req) begin
                        state     <= SRV;
                        ram_addr  <= ADDR_W'(spawn_col);
                        ram_wdata <= spawn_char;
                        ram_we    <= spawn_col < COL_W'(COLS);
                        spawn_ack <= 1'b1;
                    end else if (start) begin
                        state    <= RD;
                        busy     <= 1'b1;
                        ram_addr <= ADDR_W'(CELLS - 1);
                    end
                end
                RD: state <= CHK;
                CHK: begin
                    if (ram_rdata != '0) begin
                        state      <= is_last_row ? CL : MV;
                        ram_addr   <= is_last_row ? p : p + ADDR_W'(COLS);
                        ram_wdata  <= is_last_row ? '0 : ram_rdata;
                        ram_we     <= 1'b1;
                        miss_pulse <= is_last_row;
                        if (is_last_row && !(&miss_cnt))
                            miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                MV: begin
                    state     <= CL;
                    ram_addr  <= p;
                    ram_wdata <= '0;
                end
                SRV: begin
                    state    <= busy ? RD : IDLE;
                    ram_addr <= p;
                    ram_we   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (cell_done) begin
                state    <= is_zero ? IDLE : RD;
                busy     <= !is_zero;
                ram_we   <= 1'b0;
                ram_addr <= p - 1'b1;
            end
            if (take_clr) begin
                state     <= SRV;
                ram_addr  <= clr_addr;
                ram_wdata <= '0;
                ram_we    <= clr_addr < ADDR_W'(CELLS);
                clr_ack   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fall_scheduler.sv
// tb_fall_scheduler: randomized and directed checks of the fall sweep against a row-shift model
module tb_fall_scheduler;
    localparam int COLS = 70;
    localparam int CELLS = 2030;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        spawn_req = 1'b0;
    logic [6:0]  spawn_col = '0;
    logic [7:0]  spawn_char = '0;
    logic        spawn_ack;
    logic        clr_req = 1'b0;
    logic [10:0] clr_addr = '0;
    logic        clr_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata = '0;
    logic        busy;
    logic [15:0] miss_cnt;
    logic        miss_pulse;
    logic        overrun;

    logic [7:0]  mem [0:2047];
    logic [7:0]  img [0:2047];
    logic        load_img = 1'b0;
    int          busy_total = 0;
    int          pulse_total = 0;
    int          total = 0;
    int          bad = 0;
    int          exp_miss = 0;

    fall_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick),
        .spawn_req(spawn_req), .spawn_col(spawn_col), .spawn_char(spawn_char), .spawn_ack(spawn_ack),
        .clr_req(clr_req), .clr_addr(clr_addr), .clr_ack(clr_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .busy(busy), .miss_cnt(miss_cnt), .miss_pulse(miss_pulse), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 2048; i++) mem[i] <= img[i];
        end else if (ram_we) mem[ram_addr] <= ram_wdata;
        else ram_rdata <= mem[ram_addr];
        if (busy) busy_total <= busy_total + 1;
        if (miss_pulse) pulse_total <= pulse_total + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cells();
        load_img = 1'b1;
        step();
        load_img = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 2048; i++) img[i] = 8'h00;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 12000) begin
            step();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%0b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({busy, ram_we, ram_addr, ram_wdata, spawn_ack, clr_ack} !== '0) begin
            bad++;
            $display("FAIL reset_bus: got busy=%0b we=%0b addr=%0d wdata=%0h sack=%0b cack=%0b, want all 0",
                     busy, ram_we, ram_addr, ram_wdata, spawn_ack, clr_ack);
        end
        total++;
        if ({miss_cnt, miss_pulse, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_flags: got miss_cnt=%0d pulse=%0b overrun=%0b, want 0", miss_cnt, miss_pulse, overrun);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_move();
        int b0;
        clear_img();
        img[20] = 8'h41;
        load_cells();
        b0 = busy_total;
        pulse_tick();
        wait_idle("single_idle");
        total++;
        if (mem[90] !== 8'h41 || mem[20] !== 8'h00) begin
            bad++;
            $display("FAIL single_move: got c90=%0h c20=%0h, want 41 00", mem[90], mem[20]);
        end
        total++;
        if (busy_total - b0 !== 4062) begin
            bad++;
            $display("FAIL single_busy: got %0d cycles, want 4062", busy_total - b0);
        end
    endtask

    task automatic test_drop();
        int p0;
        clear_img();
        img[2029] = 8'h42;
        load_cells();
        p0 = pulse_total;
        pulse_tick();
        wait_idle("drop_idle");
        exp_miss++;
        total++;
        if (mem[2029] !== 8'h00 || pulse_total - p0 !== 1) begin
            bad++;
            $display("FAIL drop_cell: got c2029=%0h pulses=%0d, want 00 1", mem[2029], pulse_total - p0);
        end
        total++;
        if (miss_cnt !== 16'(exp_miss)) begin
            bad++;
            $display("FAIL drop_cnt: got %0d, want %0d", miss_cnt, exp_miss);
        end
    endtask

    task automatic test_stack();
        clear_img();
        img[5] = 8'h43;
        img[75] = 8'h44;
        load_cells();
        pulse_tick();
        wait_idle("stack_idle");
        total++;
        if (mem[75] !== 8'h43 || mem[145] !== 8'h44 || mem[5] !== 8'h00) begin
            bad++;
            $display("FAIL stack: got c75=%0h c145=%0h c5=%0h, want 43 44 00", mem[75], mem[145], mem[5]);
        end
    endtask

    task automatic test_clear_spawn();
        int n;
        logic seen;
        clear_img();
        img[20] = 8'h41;
        img[90] = 8'h55;
        load_cells();
        pulse_tick();
        for (int i = 0; i < 48; i++) step();
        clr_addr = 11'd90;
        clr_req = 1'b1;
        spawn_col = 7'd3;
        spawn_char = 8'h5A;
        spawn_req = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 6) begin
            step();
            n++;
            seen = clr_ack;
        end
        total++;
        if (!seen || n > 5 || !ram_we || ram_addr !== 11'd90 || ram_wdata !== 8'h00 || !busy) begin
            bad++;
            $display("FAIL clr_mid: ack=%0b after %0d we=%0b addr=%0d wdata=%0h busy=%0b, want ack<=5 we=1 addr=90 wdata=0 busy=1",
                     seen, n, ram_we, ram_addr, ram_wdata, busy);
        end
        clr_req = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 12000) begin
            step();
            n++;
            seen = spawn_ack;
        end
        total++;
        if (!seen || busy || !ram_we || ram_addr !== 11'd3 || ram_wdata !== 8'h5A) begin
            bad++;
            $display("FAIL spawn_ack: ack=%0b busy=%0b we=%0b addr=%0d wdata=%0h, want ack=1 busy=0 we=1 addr=3 wdata=5a",
                     seen, busy, ram_we, ram_addr, ram_wdata);
        end
        spawn_req = 1'b0;
        step();
        total++;
        if (mem[3] !== 8'h5A || mem[90] !== 8'h41 || mem[160] !== 8'h00 || mem[20] !== 8'h00) begin
            bad++;
            $display("FAIL clr_spawn_cells: got c3=%0h c90=%0h c160=%0h c20=%0h, want 5a 41 00 00",
                     mem[3], mem[90], mem[160], mem[20]);
        end
    endtask

    task automatic test_overrun();
        int b0;
        clear_img();
        img[20] = 8'h41;
        load_cells();
        b0 = busy_total;
        pulse_tick();
        for (int i = 0; i < 99; i++) step();
        pulse_tick();
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set: got %0b, want 1", overrun);
        end
        wait_idle("overrun_first");
        step();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL overrun_restart: busy=%0b, want 1", busy);
        end
        wait_idle("overrun_second");
        total++;
        if (mem[160] !== 8'h41 || mem[90] !== 8'h00 || mem[20] !== 8'h00 || busy_total - b0 !== 2 * 4062) begin
            bad++;
            $display("FAIL overrun_two_rows: got c160=%0h c90=%0h c20=%0h busy=%0d, want 41 00 00 8124",
                     mem[160], mem[90], mem[20], busy_total - b0);
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got %0b, want 1", overrun);
        end
    endtask

    task automatic test_random();
        logic [7:0] want [0:2047];
        int exp_cyc, m, errs, first, b0, p0, c0;
        for (int it = 0; it < 3; it++) begin
            clear_img();
            for (int i = 0; i < CELLS; i++)
                img[i] = ($urandom_range(15) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            exp_cyc = 2 * CELLS;
            m = 0;
            for (int i = 0; i < CELLS; i++) begin
                want[i] = (i < COLS) ? 8'h00 : img[i - COLS];
                if (img[i] != 8'h00) begin
                    if (i >= CELLS - COLS) m++;
                    exp_cyc += (i >= CELLS - COLS) ? 1 : 2;
                end
            end
            load_cells();
            b0 = busy_total;
            p0 = pulse_total;
            c0 = int'(miss_cnt);
            pulse_tick();
            wait_idle("random_idle");
            errs = 0;
            first = -1;
            for (int i = 0; i < CELLS; i++)
                if (mem[i] !== want[i]) begin
                    errs++;
                    if (first < 0) first = i;
                end
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL random_cells[%0d]: %0d wrong cells, first at %0d", it, errs, first);
            end
            exp_miss += m;
            total++;
            if (int'(miss_cnt) - c0 !== m || pulse_total - p0 !== m) begin
                bad++;
                $display("FAIL random_miss[%0d]: got cnt+%0d pulses=%0d, want %0d", it, int'(miss_cnt) - c0, pulse_total - p0, m);
            end
            total++;
            if (busy_total - b0 !== exp_cyc) begin
                bad++;
                $display("FAIL random_busy[%0d]: got %0d cycles, want %0d", it, busy_total - b0, exp_cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_img();
        img[2000] = 8'h30;
        load_cells();
        total++;
        if (miss_cnt !== 16'(exp_miss)) begin
            bad++;
            $display("FAIL miss_total: got %0d, want %0d", miss_cnt, exp_miss);
        end
        pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || ram_we !== 1'b0 || miss_cnt !== 16'd0 || overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got busy=%0b we=%0b miss=%0d overrun=%0b, want 0 0 0 0", busy, ram_we, miss_cnt, overrun);
        end
        for (int i = 0; i < 5; i++) step();
        total++;
        if (busy !== 1'b0 || mem[2000] !== 8'h30) begin
            bad++;
            $display("FAIL reset_pending: got busy=%0b c2000=%0h, want 0 30", busy, mem[2000]);
        end
    endtask

    task automatic test_out_of_range();
        int acks;
        clr_addr = 11'd2030;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        total++;
        if (clr_ack !== 1'b1 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL clr_oob: got ack=%0b we=%0b, want 1 0", clr_ack, ram_we);
        end
        step();
        spawn_col = 7'd70;
        spawn_char = 8'h66;
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        total++;
        if (spawn_ack !== 1'b1 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL spawn_oob: got ack=%0b we=%0b, want 1 0", spawn_ack, ram_we);
        end
        step();
        clr_addr = 11'd500;
        clr_req = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (clr_ack) acks++;
        end
        clr_req = 1'b0;
        total++;
        if (acks !== 2) begin
            bad++;
            $display("FAIL clr_held: got %0d acks in 4 cycles, want 2", acks);
        end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_drop();
        test_stack();
        test_clear_spawn();
        test_overrun();
        test_random();
        test_reset_mid();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
